// File: rtl/responder_host_ctrl_if.sv
// Key, switch and countdown-timer signals between the quiz host controller and its surroundings.
interface responder_host_ctrl_if #(
    parameter int NPLAYER = 4
);
    logic               Host_Start;
    logic               Host_Clear;
    logic               Time_Load;
    logic [7:0]         Time_Sw;
    logic [NPLAYER-1:0] Player_Key;
    logic               Block_Sel;
    logic               Timer_Start;
    logic               Timer_Clr;
    logic               Set_Time;
    logic [7:0]         Change_Time;
    logic [3:0]         Winner;
    logic [NPLAYER-1:0] LED_Player;
    logic               Foul;
    logic               Buzzer_Answer;

    modport master (
        input  Host_Start, Host_Clear, Time_Load, Time_Sw, Player_Key, Block_Sel,
        output Timer_Start, Timer_Clr, Set_Time, Change_Time, Winner, LED_Player,
               Foul, Buzzer_Answer
    );

    modport slave (
        output Host_Start, Host_Clear, Time_Load, Time_Sw, Player_Key, Block_Sel,
        input  Timer_Start, Timer_Clr, Set_Time, Change_Time, Winner, LED_Player,
               Foul, Buzzer_Answer
    );
endinterface

// File: rtl/responder_host_ctrl.sv
// Quiz responder host: arms the countdown, latches the first player key, flags false starts.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | waiting for host start; a player key here is a foul
// S_ARMED   | countdown running, first player key wins
// S_LOCKED  | winner latched, timer frozen
// S_TIMEOUT | timer reported time-over, answers refused
// S_FOUL    | false-start player displayed
module responder_host_ctrl #(
    parameter int NPLAYER      = 4,
    parameter int BUZZ_CYCLES  = 25_000_000,
    parameter int DEFAULT_TIME = 9
) (
    input logic                   CLK,
    input logic                   RST,
    responder_host_ctrl_if.master bus
);
    localparam int CW = $clog2(BUZZ_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_LOCKED, S_TIMEOUT, S_FOUL} state_t;

    state_t state_q, state_d;

    logic [2:0]         ctl_s1, ctl_s2, ctl_prev;
    logic [NPLAYER-1:0] key_s1, key_s2, key_prev;
    logic               blk_s1, blk_s2;

    logic               start_edge, clear_edge, load_edge, key_any;
    logic [NPLAYER-1:0] key_edge;
    logic [3:0]         key_idx;
    logic [3:0]         win_num;
    logic [NPLAYER-1:0] win_led;

    logic               timer_start_q, timer_start_d;
    logic               timer_clr_q, timer_clr_d;
    logic               set_time_q, set_time_d;
    logic [7:0]         change_time_q, change_time_d;
    logic [3:0]         winner_q, winner_d;
    logic [NPLAYER-1:0] led_q, led_d;
    logic               foul_q, foul_d;
    logic               buzz_start;
    logic               buzz_on;
    logic [CW-1:0]      buzz_cnt;

    assign start_edge = ctl_s2[0] & ~ctl_prev[0];
    assign clear_edge = ctl_s2[1] & ~ctl_prev[1];
    assign load_edge  = ctl_s2[2] & ~ctl_prev[2];
    assign key_edge   = key_s2 & ~key_prev;
    assign key_any    = |key_edge;

    // Scanning from the top lets the lowest-numbered pressing player win.
    always_comb begin
        key_idx = '0;
        for (int i = NPLAYER - 1; i >= 0; i--) begin
            if (key_edge[i]) key_idx = 4'(i);
        end
    end

    assign win_num = key_idx + 4'd1;
    assign win_led = NPLAYER'(1) << key_idx;

    always_comb begin
        state_d       = state_q;
        timer_start_d = timer_start_q;
        timer_clr_d   = 1'b0;
        set_time_d    = 1'b0;
        change_time_d = change_time_q;
        winner_d      = winner_q;
        led_d         = led_q;
        foul_d        = foul_q;
        buzz_start    = 1'b0;
        if (clear_edge) begin
            state_d       = S_IDLE;
            timer_start_d = 1'b0;
            timer_clr_d   = 1'b1;
            winner_d      = 4'd10;
            led_d         = '0;
            foul_d        = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_any) begin
                        state_d    = S_FOUL;
                        winner_d   = win_num;
                        led_d      = win_led;
                        foul_d     = 1'b1;
                        buzz_start = 1'b1;
                    end else if (start_edge) begin
                        state_d       = S_ARMED;
                        timer_start_d = 1'b1;
                    end
                    if (load_edge) begin
                        set_time_d    = 1'b1;
                        change_time_d = (bus.Time_Sw > 8'd99) ? 8'd99 : bus.Time_Sw;
                    end
                end
                S_ARMED: begin
                    if (key_any) begin
                        state_d       = S_LOCKED;
                        winner_d      = win_num;
                        led_d         = win_led;
                        timer_start_d = 1'b0;
                        buzz_start    = 1'b1;
                    end else if (blk_s2) begin
                        state_d       = S_TIMEOUT;
                        timer_start_d = 1'b0;
                    end
                end
                S_LOCKED, S_TIMEOUT, S_FOUL: state_d = state_q;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctl_s1        <= '0;
            ctl_s2        <= '0;
            ctl_prev      <= '0;
            key_s1        <= '0;
            key_s2        <= '0;
            key_prev      <= '0;
            blk_s1        <= 1'b0;
            blk_s2        <= 1'b0;
            state_q       <= S_IDLE;
            timer_start_q <= 1'b0;
            timer_clr_q   <= 1'b1;
            set_time_q    <= 1'b0;
            change_time_q <= 8'(DEFAULT_TIME);
            winner_q      <= 4'd10;
            led_q         <= '0;
            foul_q        <= 1'b0;
            buzz_on       <= 1'b0;
            buzz_cnt      <= '0;
        end else begin
            ctl_s1        <= {bus.Time_Load, bus.Host_Clear, bus.Host_Start};
            ctl_s2        <= ctl_s1;
            ctl_prev      <= ctl_s2;
            key_s1        <= bus.Player_Key;
            key_s2        <= key_s1;
            key_prev      <= key_s2;
            blk_s1        <= bus.Block_Sel;
            blk_s2        <= blk_s1;
            state_q       <= state_d;
            timer_start_q <= timer_start_d;
            timer_clr_q   <= timer_clr_d;
            set_time_q    <= set_time_d;
            change_time_q <= change_time_d;
            winner_q      <= winner_d;
            led_q         <= led_d;
            foul_q        <= foul_d;
            // Buzzer down-counter; a running pulse is never restarted, only cut by a clear.
            if (clear_edge) begin
                buzz_on  <= 1'b0;
                buzz_cnt <= '0;
            end else if (buzz_start && !buzz_on) begin
                buzz_on  <= 1'b1;
                buzz_cnt <= CW'(BUZZ_CYCLES - 1);
            end else if (buzz_on) begin
                if (buzz_cnt == '0) buzz_on <= 1'b0;
                else                buzz_cnt <= buzz_cnt - CW'(1);
            end
        end
    end

    assign bus.Timer_Start   = timer_start_q;
    assign bus.Timer_Clr     = timer_clr_q;
    assign bus.Set_Time      = set_time_q;
    assign bus.Change_Time   = change_time_q;
    assign bus.Winner        = winner_q;
    assign bus.LED_Player    = led_q;
    assign bus.Foul          = foul_q;
    assign bus.Buzzer_Answer = buzz_on;
endmodule

// File: tb/tb_responder_host_ctrl.sv
// Directed bench for responder_host_ctrl: NPLAYER=4, BUZZ_CYCLES=8, DEFAULT_TIME=9.
module tb_responder_host_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    responder_host_ctrl_if #(.NPLAYER(4)) bus();

    responder_host_ctrl #(.NPLAYER(4), .BUZZ_CYCLES(8), .DEFAULT_TIME(9)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.Host_Start = 1'b0;
        bus.Host_Clear = 1'b0;
        bus.Time_Load  = 1'b0;
        bus.Time_Sw    = 8'd0;
        bus.Player_Key = 4'b0000;
        bus.Block_Sel  = 1'b0;
    endtask

    task automatic do_clear();
        bus.Player_Key = 4'b0000;
        bus.Host_Start = 1'b0;
        bus.Block_Sel  = 1'b0;
        bus.Host_Clear = 1'b1;
        cyc(3);
        checks++;
        if (bus.Winner !== 4'd10 || bus.Timer_Clr !== 1'b1) begin
            errors++;
            $display("FAIL clear: winner=%0d clr=%0b, need winner=10 clr=1", bus.Winner, bus.Timer_Clr);
        end
        bus.Host_Clear = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1'b1;
        cyc(2);
        checks++;
        if (bus.Timer_Clr !== 1'b1) begin errors++; $display("FAIL rst_clr: got %0b need 1", bus.Timer_Clr); end
        checks++;
        if (bus.Winner !== 4'd10 || bus.LED_Player !== 4'b0000 || bus.Foul !== 1'b0) begin
            errors++;
            $display("FAIL rst_winner: winner=%0d led=%b foul=%0b, need 10/0000/0", bus.Winner, bus.LED_Player, bus.Foul);
        end
        checks++;
        if (bus.Timer_Start !== 1'b0 || bus.Set_Time !== 1'b0 || bus.Buzzer_Answer !== 1'b0) begin
            errors++;
            $display("FAIL rst_ctl: start=%0b set=%0b buzz=%0b, need 0/0/0", bus.Timer_Start, bus.Set_Time, bus.Buzzer_Answer);
        end
        RST = 1'b0;
        cyc(1);
        checks++;
        if (bus.Timer_Clr !== 1'b0) begin errors++; $display("FAIL rst_clr_drop: got %0b need 0", bus.Timer_Clr); end
        cyc(5);
        checks++;
        if (bus.Winner !== 4'd10 || bus.Change_Time !== 8'd9 || bus.Timer_Start !== 1'b0) begin
            errors++;
            $display("FAIL rst_settle: winner=%0d time=%0d start=%0b, need 10/9/0", bus.Winner, bus.Change_Time, bus.Timer_Start);
        end
    endtask

    task automatic load_once(input logic [7:0] sw, input logic [7:0] exp_val);
        int pulses = 0;
        int first  = -1;
        logic [7:0] val = 8'd0;
        bus.Time_Sw   = sw;
        bus.Time_Load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (bus.Set_Time === 1'b1) begin
                if (first < 0) first = i;
                pulses++;
                val = bus.Change_Time;
            end
        end
        checks++;
        if (pulses != 1 || first != 2) begin
            errors++;
            $display("FAIL load_pulse sw=%0d: pulses=%0d at=%0d, need 1 at 2", sw, pulses, first);
        end
        checks++;
        if (val !== exp_val) begin errors++; $display("FAIL load_value sw=%0d: got %0d need %0d", sw, val, exp_val); end
        bus.Time_Load = 1'b0;
        cyc(3);
        checks++;
        if (bus.Change_Time !== exp_val) begin errors++; $display("FAIL load_hold: got %0d need %0d", bus.Change_Time, exp_val); end
    endtask

    task automatic test_time_load();
        load_once(8'd150, 8'd99);
        load_once(8'd25, 8'd25);
    endtask

    task automatic test_lock();
        int n = 1;
        int g = 0;
        int pulses = 0;
        bus.Host_Start = 1'b1;
        cyc(3);
        checks++;
        if (bus.Timer_Start !== 1'b1) begin errors++; $display("FAIL lock_arm: start=%0b need 1", bus.Timer_Start); end
        bus.Host_Start = 1'b0;
        bus.Player_Key = 4'b0110;
        cyc(2);
        checks++;
        if (bus.Winner !== 4'd10) begin errors++; $display("FAIL lock_early: winner=%0d need 10", bus.Winner); end
        cyc(1);
        checks++;
        if (bus.Winner !== 4'd2 || bus.LED_Player !== 4'b0010 || bus.Timer_Start !== 1'b0 ||
            bus.Buzzer_Answer !== 1'b1 || bus.Foul !== 1'b0) begin
            errors++;
            $display("FAIL lock_win: winner=%0d led=%b start=%0b buzz=%0b foul=%0b, need 2/0010/0/1/0",
                     bus.Winner, bus.LED_Player, bus.Timer_Start, bus.Buzzer_Answer, bus.Foul);
        end
        while (bus.Buzzer_Answer === 1'b1 && g < 20) begin
            cyc(1);
            if (bus.Buzzer_Answer === 1'b1) n++;
            g++;
        end
        checks++;
        if (n != 8) begin errors++; $display("FAIL lock_buzz_len: got %0d need 8", n); end
        bus.Time_Sw   = 8'd50;
        bus.Time_Load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (bus.Set_Time === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.Change_Time !== 8'd25) begin
            errors++;
            $display("FAIL lock_load_ignored: pulses=%0d time=%0d, need 0/25", pulses, bus.Change_Time);
        end
        bus.Time_Load  = 1'b0;
        bus.Player_Key = 4'b0000;
        cyc(2);
        bus.Player_Key = 4'b0001;
        cyc(4);
        checks++;
        if (bus.Winner !== 4'd2) begin errors++; $display("FAIL lock_hold: winner=%0d need 2", bus.Winner); end
        bus.Player_Key = 4'b0000;
        bus.Host_Clear = 1'b1;
        cyc(3);
        checks++;
        if (bus.Winner !== 4'd10 || bus.LED_Player !== 4'b0000 || bus.Timer_Clr !== 1'b1) begin
            errors++;
            $display("FAIL lock_clear: winner=%0d led=%b clr=%0b, need 10/0000/1", bus.Winner, bus.LED_Player, bus.Timer_Clr);
        end
        cyc(1);
        checks++;
        if (bus.Timer_Clr !== 1'b0) begin errors++; $display("FAIL lock_clr_pulse: clr=%0b need 0", bus.Timer_Clr); end
        bus.Host_Clear = 1'b0;
        cyc(2);
    endtask

    task automatic test_timeout();
        bus.Host_Start = 1'b1;
        cyc(3);
        bus.Host_Start = 1'b0;
        bus.Block_Sel  = 1'b1;
        cyc(2);
        checks++;
        if (bus.Timer_Start !== 1'b1) begin errors++; $display("FAIL tout_early: start=%0b need 1", bus.Timer_Start); end
        cyc(1);
        checks++;
        if (bus.Timer_Start !== 1'b0) begin errors++; $display("FAIL tout_stop: start=%0b need 0", bus.Timer_Start); end
        bus.Player_Key = 4'b0001;
        cyc(4);
        checks++;
        if (bus.Winner !== 4'd10 || bus.Buzzer_Answer !== 1'b0) begin
            errors++;
            $display("FAIL tout_key: winner=%0d buzz=%0b, need 10/0", bus.Winner, bus.Buzzer_Answer);
        end
        do_clear();
    endtask

    task automatic test_key_and_timeout();
        bus.Host_Start = 1'b1;
        cyc(3);
        bus.Host_Start = 1'b0;
        bus.Block_Sel  = 1'b1;
        bus.Player_Key = 4'b0100;
        cyc(3);
        checks++;
        if (bus.Winner !== 4'd3 || bus.Timer_Start !== 1'b0 || bus.Buzzer_Answer !== 1'b1) begin
            errors++;
            $display("FAIL key_tout: winner=%0d start=%0b buzz=%0b, need 3/0/1", bus.Winner, bus.Timer_Start, bus.Buzzer_Answer);
        end
        do_clear();
    endtask

    task automatic test_foul();
        bus.Player_Key = 4'b1000;
        cyc(3);
        checks++;
        if (bus.Winner !== 4'd4 || bus.Foul !== 1'b1 || bus.LED_Player !== 4'b1000 ||
            bus.Buzzer_Answer !== 1'b1 || bus.Timer_Start !== 1'b0) begin
            errors++;
            $display("FAIL foul_set: winner=%0d foul=%0b led=%b buzz=%0b start=%0b, need 4/1/1000/1/0",
                     bus.Winner, bus.Foul, bus.LED_Player, bus.Buzzer_Answer, bus.Timer_Start);
        end
        bus.Host_Start = 1'b1;
        cyc(3);
        checks++;
        if (bus.Timer_Start !== 1'b0 || bus.Winner !== 4'd4 || bus.Buzzer_Answer !== 1'b1) begin
            errors++;
            $display("FAIL foul_start_ignored: start=%0b winner=%0d buzz=%0b, need 0/4/1", bus.Timer_Start, bus.Winner, bus.Buzzer_Answer);
        end
        bus.Host_Start = 1'b0;
        bus.Player_Key = 4'b0000;
        bus.Host_Clear = 1'b1;
        cyc(3);
        checks++;
        if (bus.Winner !== 4'd10 || bus.Foul !== 1'b0 || bus.Buzzer_Answer !== 1'b0 || bus.Timer_Clr !== 1'b1) begin
            errors++;
            $display("FAIL foul_clear: winner=%0d foul=%0b buzz=%0b clr=%0b, need 10/0/0/1",
                     bus.Winner, bus.Foul, bus.Buzzer_Answer, bus.Timer_Clr);
        end
        cyc(1);
        checks++;
        if (bus.Timer_Clr !== 1'b0 || bus.Buzzer_Answer !== 1'b0) begin
            errors++;
            $display("FAIL foul_clr_pulse: clr=%0b buzz=%0b, need 0/0", bus.Timer_Clr, bus.Buzzer_Answer);
        end
        bus.Host_Clear = 1'b0;
        cyc(2);
    endtask

    task automatic test_key_start_same();
        bus.Host_Start = 1'b1;
        bus.Player_Key = 4'b0010;
        cyc(3);
        checks++;
        if (bus.Foul !== 1'b1 || bus.Winner !== 4'd2 || bus.Timer_Start !== 1'b0) begin
            errors++;
            $display("FAIL key_start_same: foul=%0b winner=%0d start=%0b, need 1/2/0", bus.Foul, bus.Winner, bus.Timer_Start);
        end
        do_clear();
    endtask

    task automatic test_reset_mid();
        bus.Host_Start = 1'b1;
        cyc(3);
        bus.Host_Start = 1'b0;
        bus.Player_Key = 4'b0100;
        cyc(4);
        checks++;
        if (bus.Winner !== 4'd3 || bus.Buzzer_Answer !== 1'b1) begin
            errors++;
            $display("FAIL mid_locked: winner=%0d buzz=%0b, need 3/1", bus.Winner, bus.Buzzer_Answer);
        end
        RST = 1'b1;
        cyc(1);
        checks++;
        if (bus.Winner !== 4'd10 || bus.LED_Player !== 4'b0000 || bus.Timer_Start !== 1'b0 ||
            bus.Timer_Clr !== 1'b1 || bus.Buzzer_Answer !== 1'b0 || bus.Foul !== 1'b0 ||
            bus.Set_Time !== 1'b0 || bus.Change_Time !== 8'd9) begin
            errors++;
            $display("FAIL mid_reset: winner=%0d led=%b start=%0b clr=%0b buzz=%0b foul=%0b set=%0b time=%0d, need 10/0000/0/1/0/0/0/9",
                     bus.Winner, bus.LED_Player, bus.Timer_Start, bus.Timer_Clr, bus.Buzzer_Answer,
                     bus.Foul, bus.Set_Time, bus.Change_Time);
        end
        bus.Player_Key = 4'b0000;
        cyc(1);
        RST = 1'b0;
        cyc(2);
    endtask

    initial begin
        test_reset();
        test_time_load();
        test_lock();
        test_timeout();
        test_key_and_timeout();
        test_foul();
        test_key_start_same();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
